// File: rtl/cs_acc_pkg.sv
// Shared constants, stage-A payload type and the clamping adder used by the dot-product accumulator.
// The clamping adder only participates when CS_ACC_SAT_EN is defined.
package cs_acc_pkg;

    localparam int CS_IN_SIZE  = 20;
    localparam int CS_ACC_SIZE = 32;
    localparam int CS_CNT_SIZE = 16;
    localparam int CS_MAX_ACC  = 64;

    // p is sized for the widest supported input; narrower inputs are sign-extended into it.
    typedef struct packed {
        logic signed [CS_IN_SIZE:0] p;
        logic                       last;
    } cs_payload_t;

    typedef struct packed {
        logic signed [CS_MAX_ACC-1:0] sum;
        logic                         ovf;
    } cs_sat_t;

    // Adds a+b exactly, then clamps to the signed range of a w-bit result.
    function automatic cs_sat_t sat_add(
        input logic signed [CS_MAX_ACC-1:0] a,
        input logic signed [CS_MAX_ACC-1:0] b,
        input int                           w
    );
        logic signed [CS_MAX_ACC:0] s;
        logic signed [CS_MAX_ACC:0] one;
        logic signed [CS_MAX_ACC:0] hi;
        logic signed [CS_MAX_ACC:0] lo;
        cs_sat_t                    r;
        one = {{CS_MAX_ACC{1'b0}}, 1'b1};
        s   = {a[CS_MAX_ACC-1], a} + {b[CS_MAX_ACC-1], b};
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        r.ovf = 1'b1;
        if (s > hi) begin
            r.sum = CS_MAX_ACC'(hi);
        end else if (s < lo) begin
            r.sum = CS_MAX_ACC'(lo);
        end else begin
            r.sum = CS_MAX_ACC'(s);
            r.ovf = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/cs_cpa_stage.sv
// Stage A: resolves the carry-save pair with a sign-extending add and registers it with last/valid.
// One cycle latency; the register only advances while i_en is high.
module cs_cpa_stage
    import cs_acc_pkg::*;
#(
    parameter int IN_SIZE = CS_IN_SIZE
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_vld,
    input  logic               i_last,
    input  logic [IN_SIZE-1:0] i_sum,
    input  logic [IN_SIZE-1:0] i_carry,
    output logic               o_vld,
    output cs_payload_t        o_pay
);

    logic signed [CS_IN_SIZE:0] w_p;
    logic                       r_vld;
    cs_payload_t                r_pay;

    assign w_p = (CS_IN_SIZE+1)'($signed(i_sum)) + (CS_IN_SIZE+1)'($signed(i_carry));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= 1'b0;
            r_pay <= '0;
        end else if (i_en) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_pay.p    <= w_p;
                r_pay.last <= i_last;
            end
        end
    end

    assign o_vld = r_vld;
    assign o_pay = r_pay;

endmodule

// File: rtl/cs_dot_accumulator.sv
// Resolves carry-save beats and accumulates each last_i-delimited frame into a signed result.
// Last beat accepted in cycle t -> valid_o in cycle t+2; a held result stalls the whole pipe.
// CS_ACC_SAT_EN: clamp on overflow and report a per-frame sticky flag on sat_o (else wrap, sat_o=0).
module cs_dot_accumulator
    import cs_acc_pkg::*;
#(
    parameter int IN_SIZE  = CS_IN_SIZE,
    parameter int ACC_SIZE = CS_ACC_SIZE,
    parameter int CNT_SIZE = CS_CNT_SIZE
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [IN_SIZE-1:0]  cs_sum_i,
    input  logic [IN_SIZE-1:0]  cs_carry_i,
    input  logic                valid_i,
    input  logic                last_i,
    output logic                ready_o,
    output logic [ACC_SIZE-1:0] acc_o,
    output logic [CNT_SIZE-1:0] beats_o,
    output logic                sat_o,
    output logic                valid_o,
    input  logic                ready_i
);

    if (ACC_SIZE < IN_SIZE + 1) begin : g_chk_acc
        $error("cs_dot_accumulator: ACC_SIZE must be >= IN_SIZE+1");
    end
    if (ACC_SIZE > CS_MAX_ACC) begin : g_chk_max
        $error("cs_dot_accumulator: ACC_SIZE exceeds CS_MAX_ACC");
    end
    if (IN_SIZE > CS_IN_SIZE) begin : g_chk_in
        $error("cs_dot_accumulator: IN_SIZE exceeds CS_IN_SIZE");
    end

    logic                       w_en;
    logic                       w_a_vld;
    logic                       w_fire;
    cs_payload_t                w_a_pay;
    logic signed [ACC_SIZE-1:0] w_p_ext;
    logic signed [ACC_SIZE-1:0] w_nxt;
    logic [CNT_SIZE-1:0]        w_cnt_n;

    logic signed [ACC_SIZE-1:0] r_acc;
    logic [CNT_SIZE-1:0]        r_cnt;
    logic [ACC_SIZE-1:0]        r_acc_o;
    logic [CNT_SIZE-1:0]        r_beats_o;
    logic                       r_vld_o;

    assign w_en    = ~(r_vld_o & ~ready_i);
    assign ready_o = w_en;

    cs_cpa_stage #(
        .IN_SIZE (IN_SIZE)
    ) u_cpa (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_en    (w_en),
        .i_vld   (valid_i),
        .i_last  (last_i),
        .i_sum   (cs_sum_i),
        .i_carry (cs_carry_i),
        .o_vld   (w_a_vld),
        .o_pay   (w_a_pay)
    );

    assign w_fire  = w_a_vld & w_en;
    assign w_p_ext = ACC_SIZE'(w_a_pay.p);
    assign w_cnt_n = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

`ifdef CS_ACC_SAT_EN
    cs_sat_t w_sa;
    logic    r_sticky;
    logic    r_sat_o;

    assign w_sa  = sat_add(CS_MAX_ACC'(r_acc), CS_MAX_ACC'(w_p_ext), ACC_SIZE);
    assign w_nxt = ACC_SIZE'(w_sa.sum);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sticky <= 1'b0;
            r_sat_o  <= 1'b0;
        end else if (w_fire) begin
            if (w_a_pay.last) begin
                r_sat_o  <= r_sticky | w_sa.ovf;
                r_sticky <= 1'b0;
            end else begin
                r_sticky <= r_sticky | w_sa.ovf;
            end
        end
    end

    assign sat_o = r_sat_o;
`else
    assign w_nxt = r_acc + w_p_ext;
    assign sat_o = 1'b0;
`endif

    // A new result landing in the same cycle as a handoff overrides the clear, so valid_o never bubbles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_acc_o   <= '0;
            r_beats_o <= '0;
            r_vld_o   <= 1'b0;
        end else begin
            if (r_vld_o && ready_i) begin
                r_vld_o <= 1'b0;
            end
            if (w_fire) begin
                if (w_a_pay.last) begin
                    r_acc_o   <= w_nxt;
                    r_beats_o <= w_cnt_n;
                    r_vld_o   <= 1'b1;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_acc <= w_nxt;
                    r_cnt <= w_cnt_n;
                end
            end
        end
    end

    assign acc_o   = r_acc_o;
    assign beats_o = r_beats_o;
    assign valid_o = r_vld_o;

endmodule
